// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its consumers.
// Holds the FSM encoding, the default bubble word and the instruction field layout.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   // Field positions used by the decoder
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 28;
   localparam int RD_MSB = 27;
   localparam int RD_LSB = 22;
   localparam int RS_MSB = 21;
   localparam int RS_LSB = 16;
   localparam int RT_MSB = 15;
   localparam int RT_LSB = 10;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection; arithmetic wraps modulo 2^32.
// Redirect wins over sequential advance; otherwise the PC holds.
module pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc
);

   logic [31:0] pc_nxt;

   always_comb begin
      pc_nxt = pc;
      if (redirect)     pc_nxt = redirect_pc;
      else if (advance) pc_nxt = pc + PC_STEP;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc <= RESET_PC;
      else     pc <= pc_nxt;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: BOOT/RUN/HOLD control, IF/ID register and activity counters.
// A stall freezes everything except the stall counter; a redirect overrides it and squashes ID.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd1,
   parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        valid_out,
   output logic        id_kill,
   output logic [15:0] stall_cnt,
   output logic [15:0] fetch_cnt
);

   fetch_state_t state, state_nxt;
   logic         do_fetch, do_hold;
   logic [31:0]  pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_fetch  = 1'b0;
      do_hold   = 1'b0;
      if (redirect) begin
         state_nxt = RUN;
      end else begin
         case (state)
            BOOT: state_nxt = RUN;
            RUN, HOLD: begin
               if (stall) begin
                  state_nxt = HOLD;
                  do_hold   = 1'b1;
               end else begin
                  state_nxt = RUN;
                  do_fetch  = 1'b1;
               end
            end
            default: state_nxt = BOOT;
         endcase
      end
   end

   pc_gen #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_gen (
      .clk         (clk),
      .rst         (rst),
      .advance     (do_fetch),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc)
   );

   assign imem_addr = pc;

   // pc_out is left untouched on redirect; valid_out=0 marks the bubble instead
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_out <= NOP_INSTR;
         pc_out    <= 32'h0;
         valid_out <= 1'b0;
         id_kill   <= 1'b0;
         stall_cnt <= 16'h0;
         fetch_cnt <= 16'h0;
      end else begin
         id_kill <= redirect;
         if (redirect) begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
         end else if (do_fetch) begin
            instr_out <= imem_data;
            pc_out    <= pc;
            valid_out <= 1'b1;
            fetch_cnt <= sat_inc16(fetch_cnt);
         end else if (do_hold) begin
            stall_cnt <= sat_inc16(stall_cnt);
         end
      end
   end

endmodule
